// File: rtl/dmem_responder_if.sv
// Load/store port bundle between the core (master) and the data-memory responder (slave).
// Request channel: valid/ready, fields qualified by req_valid.
// Response channel: valid/ready, rdata/err held while rsp_valid && !rsp_ready.
interface dmem_responder_if;
  logic        req_valid;
  logic        req_ready;
  logic        req_we;
  logic [31:0] req_addr;
  logic [2:0]  req_funct3;
  logic [31:0] req_wdata;
  logic        rsp_valid;
  logic        rsp_ready;
  logic [31:0] rsp_rdata;
  logic        rsp_err;

  modport master (
    output req_valid, req_we, req_addr, req_funct3, req_wdata, rsp_ready,
    input  req_ready, rsp_valid, rsp_rdata, rsp_err
  );

  modport slave (
    input  req_valid, req_we, req_addr, req_funct3, req_wdata, rsp_ready,
    output req_ready, rsp_valid, rsp_rdata, rsp_err
  );
endinterface

// File: rtl/dmem_responder.sv
// Data RAM responder for the core load/store port with RV32I byte/half/word accesses.
// Latency: rsp_valid rises LATENCY+1 cycles after accept; one access in flight.
// Backpressure: req_ready only in IDLE; response held until rsp_ready.
// Optional feature macro DMEM_MISALIGN_EN: misaligned/unsupported accesses fault (rsp_err).
`ifndef DATA_WIDTH
`define DATA_WIDTH 32
`endif
`ifndef ADDR_WIDTH
`define ADDR_WIDTH 10
`endif

module dmem_responder #(
  parameter int    DATA_WIDTH = `DATA_WIDTH,
  parameter int    ADDR_WIDTH = `ADDR_WIDTH,
  parameter int    LATENCY    = 2,
  parameter string MEM_FILE   = "src/data_mem.mem"
) (
  input logic             clk,
  input logic             reset,
  dmem_responder_if.slave bus
);
  localparam int DEPTH = 2 ** ADDR_WIDTH;
  localparam int CW    = (LATENCY > 0) ? $clog2(LATENCY + 1) : 1;

  // Only a 32-bit data path is implemented.
  if (DATA_WIDTH != 32) begin : g_bad_width
    $error("dmem_responder supports DATA_WIDTH = 32 only");
  end

  // The RAM image path belongs to the preload flow outside this logic.
  localparam string unused_mem_file = MEM_FILE;

  typedef enum logic [1:0] {IDLE, WAIT, RESP} state_t;
  state_t state, state_nxt;

  logic [CW-1:0] cnt;
  logic          lat_we;
  logic [31:0]   lat_addr;
  logic [2:0]    lat_funct3;
  logic [31:0]   lat_wdata;

  logic          accept;
  logic          commit;
  logic          c_we;
  logic [31:0]   c_addr;
  logic [2:0]    c_funct3;
  logic [31:0]   c_wdata;

  logic [31:0]   eff_addr;
  logic          f3_ok;
  logic          suppress;
`ifdef DMEM_MISALIGN_EN
  logic          misalign;
`endif
  logic [ADDR_WIDTH-1:0] widx;
  logic [1:0]    lane;
  logic [3:0]    wmask;
  logic [31:0]   wbus;
  logic [31:0]   rword;
  logic [7:0]    ld_byte;
  logic [15:0]   ld_half;
  logic [31:0]   ld_val;
  logic [31:0]   rsp_rdata_q;
  logic          unused_addr;

  logic [31:0]   ram [DEPTH];

  assign accept = bus.req_valid && (state == IDLE);

  // With zero wait states the access commits on the accept edge from the live request
  // fields; otherwise it commits from the latched copy when the counter leaves 1.
  assign commit   = (LATENCY == 0) ? accept : ((state == WAIT) && (cnt == CW'(1)));
  assign c_we     = (LATENCY == 0) ? bus.req_we     : lat_we;
  assign c_addr   = (LATENCY == 0) ? bus.req_addr   : lat_addr;
  assign c_funct3 = (LATENCY == 0) ? bus.req_funct3 : lat_funct3;
  assign c_wdata  = (LATENCY == 0) ? bus.req_wdata  : lat_wdata;

  // State register
  always_ff @(posedge clk) begin
    if (reset) state <= IDLE;
    else       state <= state_nxt;
  end

  // Next state and handshake outputs
  always_comb begin
    state_nxt     = state;
    bus.req_ready = 1'b0;
    bus.rsp_valid = 1'b0;
    case (state)
      IDLE: begin
        bus.req_ready = 1'b1;
        if (accept) state_nxt = (LATENCY == 0) ? RESP : WAIT;
      end
      WAIT: begin
        if (cnt == CW'(1)) state_nxt = RESP;
      end
      RESP: begin
        bus.rsp_valid = 1'b1;
        if (bus.rsp_ready) state_nxt = IDLE;
      end
      default: state_nxt = IDLE;
    endcase
  end

  // Capture the request on accept and count down the wait states
  always_ff @(posedge clk) begin
    if (reset) begin
      cnt        <= '0;
      lat_we     <= 1'b0;
      lat_addr   <= '0;
      lat_funct3 <= '0;
      lat_wdata  <= '0;
    end else if (accept) begin
      cnt        <= CW'(LATENCY);
      lat_we     <= bus.req_we;
      lat_addr   <= bus.req_addr;
      lat_funct3 <= bus.req_funct3;
      lat_wdata  <= bus.req_wdata;
    end else if (state == WAIT) begin
      cnt <= cnt - CW'(1);
    end
  end

  // Decode the committing access: alignment/fault, store lanes, load extraction
  always_comb begin
    f3_ok    = 1'b1;
    eff_addr = c_addr;
`ifdef DMEM_MISALIGN_EN
    misalign = 1'b0;
`endif
    case (c_funct3)
      3'd0, 3'd4: ;
      3'd1, 3'd5: begin
`ifdef DMEM_MISALIGN_EN
        misalign = c_addr[0];
`else
        eff_addr[0] = 1'b0;
`endif
      end
      3'd2: begin
`ifdef DMEM_MISALIGN_EN
        misalign = |c_addr[1:0];
`else
        eff_addr[1:0] = 2'b00;
`endif
      end
      default: f3_ok = 1'b0;
    endcase
`ifdef DMEM_MISALIGN_EN
    suppress = !f3_ok || misalign;
`else
    suppress = !f3_ok;
`endif

    widx  = eff_addr[ADDR_WIDTH+1:2];
    lane  = eff_addr[1:0];
    rword = ram[widx];

    wmask = 4'b0000;
    wbus  = c_wdata;
    case (c_funct3[1:0])
      2'd0: begin wmask = 4'b0001 << lane; wbus = {4{c_wdata[7:0]}}; end
      2'd1: begin wmask = lane[1] ? 4'b1100 : 4'b0011; wbus = {2{c_wdata[15:0]}}; end
      2'd2: wmask = 4'b1111;
      default: wmask = 4'b0000;
    endcase
    if (!c_we || suppress) wmask = 4'b0000;

    ld_byte = rword[{lane, 3'b000} +: 8];
    ld_half = lane[1] ? rword[31:16] : rword[15:0];
    case (c_funct3)
      3'd0:    ld_val = {{24{ld_byte[7]}}, ld_byte};
      3'd1:    ld_val = {{16{ld_half[15]}}, ld_half};
      3'd2:    ld_val = rword;
      3'd4:    ld_val = {24'h0, ld_byte};
      3'd5:    ld_val = {16'h0, ld_half};
      default: ld_val = '0;
    endcase
    if (suppress) ld_val = '0;
  end

  // Upper address bits wrap the access modulo the RAM size.
  assign unused_addr = ^eff_addr[31:ADDR_WIDTH+2];

  // Byte-lane RAM writes on the commit edge; reset wins over a coinciding commit
  always_ff @(posedge clk) begin
    if (!reset && commit) begin
      for (int i = 0; i < 4; i++) begin
        if (wmask[i]) ram[widx][8*i +: 8] <= wbus[8*i +: 8];
      end
    end
  end

`ifdef DMEM_MISALIGN_EN
  logic rsp_err_q;

  // Register the response payload at commit; held untouched through RESP
  always_ff @(posedge clk) begin
    if (reset) begin
      rsp_rdata_q <= '0;
      rsp_err_q   <= 1'b0;
    end else if (commit) begin
      rsp_rdata_q <= c_we ? 32'h0 : ld_val;
      rsp_err_q   <= suppress;
    end
  end

  assign bus.rsp_err = rsp_err_q;
`else
  // Register the response payload at commit; held untouched through RESP
  always_ff @(posedge clk) begin
    if (reset)       rsp_rdata_q <= '0;
    else if (commit) rsp_rdata_q <= c_we ? 32'h0 : ld_val;
  end

  assign bus.rsp_err = 1'b0;
`endif

  assign bus.rsp_rdata = rsp_rdata_q;
endmodule

// File: tb/tb_dmem_responder.sv
// Bench for dmem_responder: a LATENCY=2 instance (directed + random traffic) and a
// LATENCY=0 instance, both checked against a byte-array model of the RAM.
// Expectations follow DMEM_MISALIGN_EN when it is defined for the build.
module tb_dmem_responder;
  localparam int AW    = 6;
  localparam int MEMB  = 4 * (1 << AW);
  localparam int LAT_A = 2;

  logic clk = 1'b0;
  logic reset;
  int   compared   = 0;
  int   mismatched = 0;

  logic [7:0] mdl [2][MEMB];

  // Free-running clock
  always #5 clk = ~clk;

  dmem_responder_if ifa ();
  dmem_responder_if ifb ();

  dmem_responder #(.DATA_WIDTH(32), .ADDR_WIDTH(AW), .LATENCY(LAT_A)) dut_a (
    .clk(clk), .reset(reset), .bus(ifa)
  );
  dmem_responder #(.DATA_WIDTH(32), .ADDR_WIDTH(AW), .LATENCY(0)) dut_b (
    .clk(clk), .reset(reset), .bus(ifb)
  );

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    compared++;
    assert (obs === exp) else begin
      mismatched++;
      $error("FAIL %s: observed 0x%08h expected 0x%08h", tag, obs, exp);
    end
  endtask

  // Reference: byte-addressed RAM with RV32I load/store rules.
  function automatic void model(input int s, input bit we, input logic [31:0] addr_in,
                                input logic [2:0] f3, input logic [31:0] wd,
                                output logic [31:0] rd, output logic err);
    int size = 4;
    bit sgn = 1'b0;
    bit ok = 1'b1;
    int base;
    logic [31:0] addr = addr_in;
    logic [31:0] v = 32'h0;
    case (f3)
      3'd0: begin size = 1; sgn = 1'b1; end
      3'd1: begin size = 2; sgn = 1'b1; end
      3'd2: size = 4;
      3'd4: size = 1;
      3'd5: size = 2;
      default: ok = 1'b0;
    endcase
    rd  = 32'h0;
    err = 1'b0;
`ifdef DMEM_MISALIGN_EN
    if (!ok || (addr % size) != 0) begin
      err = 1'b1;
      return;
    end
`else
    if (!ok) return;
    addr = addr - (addr % size);
`endif
    base = int'(addr % MEMB);
    if (we) begin
      for (int i = 0; i < size; i++) mdl[s][base + i] = wd[8*i +: 8];
    end else begin
      for (int i = 0; i < size; i++) v[8*i +: 8] = mdl[s][base + i];
      if (sgn && v[8*size - 1]) for (int i = size; i < 4; i++) v[8*i +: 8] = 8'hFF;
      rd = v;
    end
  endfunction

  task automatic drive(input int s, input logic v, input logic we, input logic [31:0] a,
                       input logic [2:0] f, input logic [31:0] d);
    if (s == 0) begin
      ifa.req_valid = v; ifa.req_we = we; ifa.req_addr = a; ifa.req_funct3 = f; ifa.req_wdata = d;
    end else begin
      ifb.req_valid = v; ifb.req_we = we; ifb.req_addr = a; ifb.req_funct3 = f; ifb.req_wdata = d;
    end
  endtask

  task automatic set_rr(input int s, input logic r);
    if (s == 0) ifa.rsp_ready = r;
    else        ifb.rsp_ready = r;
  endtask

  function automatic logic qrdy(input int s);
    return (s == 0) ? ifa.req_ready : ifb.req_ready;
  endfunction
  function automatic logic rvld(input int s);
    return (s == 0) ? ifa.rsp_valid : ifb.rsp_valid;
  endfunction
  function automatic logic [31:0] rdat(input int s);
    return (s == 0) ? ifa.rsp_rdata : ifb.rsp_rdata;
  endfunction
  function automatic logic rerr(input int s);
    return (s == 0) ? ifa.rsp_err : ifb.rsp_err;
  endfunction

  // One full transaction: accept, latency, payload, optional rsp_ready stall, handshake.
  task automatic access(input int s, input logic we, input logic [31:0] a, input logic [2:0] f,
                        input logic [31:0] d, input int hold, input logic keep_valid,
                        input string tag);
    logic [31:0] exp_rd;
    logic        exp_err;
    int          k = 0;
    int          n = 0;
    bit          found = 1'b0;
    bit          rdy_seen = 1'b0;
    int          lat = (s == 0) ? LAT_A : 0;
    model(s, we, a, f, d, exp_rd, exp_err);
    @(negedge clk);
    drive(s, 1'b1, we, a, f, d);
    while (!qrdy(s) && n < 50) begin @(negedge clk); n++; end
    check({tag, "/accept"}, 32'(qrdy(s)), 32'd1);
    while (!found && k < 20) begin
      @(negedge clk);
      k++;
      if (k == 1) drive(s, keep_valid, 1'($urandom), $urandom, 3'($urandom), $urandom);
      if (rvld(s)) found = 1'b1;
      else if (qrdy(s)) rdy_seen = 1'b1;
    end
    check({tag, "/latency"}, 32'(k), 32'(lat + 1));
    check({tag, "/ready_low"}, 32'(rdy_seen), 32'd0);
    check({tag, "/rdata"}, rdat(s), exp_rd);
    check({tag, "/err"}, 32'(rerr(s)), 32'(exp_err));
    for (int h = 0; h < hold; h++) begin
      @(negedge clk);
      check({tag, "/hold_valid"}, 32'(rvld(s)), 32'd1);
      check({tag, "/hold_rdata"}, rdat(s), exp_rd);
      check({tag, "/hold_ready"}, 32'(qrdy(s)), 32'd0);
    end
    set_rr(s, 1'b1);
    @(negedge clk);
    set_rr(s, 1'b0);
    drive(s, 1'b0, 1'b0, 32'h0, 3'd0, 32'h0);
    check({tag, "/done_valid"}, 32'(rvld(s)), 32'd0);
    check({tag, "/done_ready"}, 32'(qrdy(s)), 32'd1);
  endtask

  // Accept an access on instance A, then pulse reset during cycle k_rst after accept.
  task automatic access_reset(input logic we, input logic [31:0] a, input logic [2:0] f,
                              input logic [31:0] d, input int k_rst, input string tag);
    logic [31:0] dummy_rd;
    logic        dummy_err;
    if (LAT_A < k_rst) model(0, we, a, f, d, dummy_rd, dummy_err);
    @(negedge clk);
    check({tag, "/idle"}, 32'(qrdy(0)), 32'd1);
    drive(0, 1'b1, we, a, f, d);
    for (int k = 1; k <= k_rst; k++) begin
      @(negedge clk);
      if (k == 1) drive(0, 1'b0, 1'b0, 32'h0, 3'd0, 32'h0);
    end
    reset = 1'b1;
    @(negedge clk);
    reset = 1'b0;
    @(negedge clk);
    check({tag, "/rst_valid"}, 32'(rvld(0)), 32'd0);
    check({tag, "/rst_ready"}, 32'(qrdy(0)), 32'd1);
    check({tag, "/rst_rdata"}, rdat(0), 32'h0);
    check({tag, "/rst_err"}, 32'(rerr(0)), 32'd0);
  endtask

  initial begin
    reset = 1'b1;
    drive(0, 1'b0, 1'b0, 32'h0, 3'd0, 32'h0);
    drive(1, 1'b0, 1'b0, 32'h0, 3'd0, 32'h0);
    set_rr(0, 1'b0);
    set_rr(1, 1'b0);
    repeat (3) @(negedge clk);
    reset = 1'b0;
    @(negedge clk);
    for (int s = 0; s < 2; s++) begin
      check("reset/req_ready", 32'(qrdy(s)), 32'd1);
      check("reset/rsp_valid", 32'(rvld(s)), 32'd0);
      check("reset/rsp_rdata", rdat(s), 32'h0);
      check("reset/rsp_err", 32'(rerr(s)), 32'd0);
    end

    // Give every word of instance A a known value.
    for (int w = 0; w < (1 << AW); w++) access(0, 1'b1, 32'(w * 4), 3'd2, $urandom, 0, 1'b0, "init");

    access(0, 1'b1, 32'h10, 3'd2, 32'hDEADBEEF, 0, 1'b0, "sw_10");
    access(0, 1'b0, 32'h10, 3'd2, 32'h0, 0, 1'b0, "lw_10");
    access(0, 1'b1, 32'h04, 3'd2, 32'h11223344, 0, 1'b0, "sw_04");
    access(0, 1'b1, 32'h05, 3'd0, 32'h000000AA, 0, 1'b0, "sb_05");
    access(0, 1'b0, 32'h04, 3'd2, 32'h0, 0, 1'b0, "lw_04");
    access(0, 1'b0, 32'h06, 3'd1, 32'h0, 0, 1'b0, "lh_06");
    access(0, 1'b0, 32'h04, 3'd5, 32'h0, 0, 1'b0, "lhu_04");
    access(0, 1'b1, 32'h08, 3'd0, 32'h00000080, 0, 1'b0, "sb_08");
    access(0, 1'b0, 32'h08, 3'd0, 32'h0, 0, 1'b0, "lb_08");
    access(0, 1'b0, 32'h08, 3'd4, 32'h0, 0, 1'b0, "lbu_08");
    access(0, 1'b0, 32'h10, 3'd2, 32'h0, 3, 1'b1, "stall");

    access_reset(1'b1, 32'h20, 3'd2, 32'h12345678, 1, "rst_wait1");
    access(0, 1'b0, 32'h20, 3'd2, 32'h0, 0, 1'b0, "lw_20");
    access_reset(1'b1, 32'h24, 3'd2, 32'h0BADF00D, 2, "rst_commit");
    access(0, 1'b0, 32'h24, 3'd2, 32'h0, 0, 1'b0, "lw_24");
    access_reset(1'b0, 32'h10, 3'd2, 32'h0, 3, "rst_resp");
    access_reset(1'b1, 32'h28, 3'd2, 32'h55AA33CC, 3, "rst_after");
    access(0, 1'b0, 32'h28, 3'd2, 32'h0, 0, 1'b0, "lw_28");

    access(0, 1'b0, 32'h02, 3'd2, 32'h0, 0, 1'b0, "lw_mis");
    access(0, 1'b0, 32'h0B, 3'd1, 32'h0, 0, 1'b0, "lh_mis");
    access(0, 1'b1, 32'h0D, 3'd2, 32'hA5A5A5A5, 0, 1'b0, "sw_mis");
    access(0, 1'b0, 32'h0C, 3'd2, 32'h0, 0, 1'b0, "lw_0c");
    for (int f = 3; f < 8; f++) begin
      if (f == 4 || f == 5) continue;
      access(0, 1'b1, 32'h30, 3'(f), 32'hFFFFFFFF, 0, 1'b0, "st_badf3");
      access(0, 1'b0, 32'h30, 3'(f), 32'h0, 0, 1'b0, "ld_badf3");
    end
    access(0, 1'b0, 32'h30, 3'd2, 32'h0, 0, 1'b0, "lw_30");

    // Random traffic, including wrapped addresses and unsupported funct3 codes.
    for (int i = 0; i < 250; i++)
      access(0, 1'($urandom), $urandom, 3'($urandom_range(0, 7)), $urandom,
             $urandom_range(0, 2), 1'($urandom), "rand");

    access(1, 1'b1, 32'h0, 3'd2, 32'hCAFEF00D, 0, 1'b0, "b_sw_0");
    access(1, 1'b0, 32'h2, 3'd2, 32'h0, 0, 1'b0, "b_lw_2");
    access(1, 1'b0, 32'h0, 3'd2, 32'h0, 1, 1'b0, "b_lw_0");
    access(1, 1'b1, 32'h1, 3'd0, 32'h7E, 0, 1'b1, "b_sb_1");
    access(1, 1'b0, 32'h0, 3'd1, 32'h0, 0, 1'b0, "b_lh_0");

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end
endmodule

// File: doc/dmem_responder.md
Name: dmem_responder

Overview:
- Memory-side responder for the core's load/store port, with a valid/ready request/response handshake and a parameterised wait-state count.
- Holds the data RAM and performs RV32I sub-word accesses (byte/half/word, signed/unsigned) selected by funct3.
- Successor to the single-cycle combinational data memory. It lets the datapath's memory stage be tested against multi-cycle memory timing.

Parameters:
- DATA_WIDTH, `DATA_WIDTH (32), data word width; only 32 is supported.
- ADDR_WIDTH, `ADDR_WIDTH, number of word-address bits; the RAM depth is 2**ADDR_WIDTH words.
- LATENCY, 2, number of wait cycles between accept and the memory commit; 0 is legal.
- MEM_FILE, "src/data_mem.mem", hex file loaded into the RAM at elaboration.

Ports:
- clk  input  1  system clock; all logic updates on the rising edge.
- reset  input  1  synchronous, active-high reset.
- req_valid  input  1  the request fields below are valid.
- req_ready  output  1  the responder can accept a request.
- req_we  input  1  1 = store, 0 = load.
- req_addr  input  32  byte address.
- req_funct3  input  3  access size and sign: 0 LB/SB, 1 LH/SH, 2 LW/SW, 4 LBU, 5 LHU.
- req_wdata  input  32  store data, right-aligned.
- rsp_valid  output  1  response is available.
- rsp_ready  input  1  the core accepts the response.
- rsp_rdata  output  32  load result, already extended; 0 for stores.
- rsp_err  output  1  access fault; active only when DMEM_MISALIGN_EN is defined, tied to 0 otherwise.

Behaviour:
- States: IDLE, WAIT, RESP.
- req_ready is 1 only in IDLE.
- Accept occurs when req_valid && req_ready.
  - On accept, latch we, addr, funct3 and wdata, and load the wait counter with LATENCY.
  - Next state is WAIT, or RESP directly when LATENCY = 0.
- WAIT:
  - The counter decrements each cycle.
  - On the edge where the counter leaves 1, perform the commit and enter RESP.
- Commit edge:
  - Word index = addr[ADDR_WIDTH+1:2]. Upper address bits are ignored, so accesses wrap modulo the RAM size.
  - Store: write only the selected byte lanes.
    - SB: lane addr[1:0] gets wdata[7:0].
    - SH: lanes {addr[1],0} and {addr[1],1} get wdata[15:0].
    - SW: all four lanes.
  - Load: register the extracted, extended value into rsp_rdata.
    - LB/LH sign-extend; LBU/LHU zero-extend.
    - Lane select is the same as for stores.
- Latency: the cycle after accept is cycle 1; rsp_valid rises at cycle LATENCY+1.
- RESP:
  - rsp_valid = 1, and rsp_rdata and rsp_err are held stable until rsp_ready = 1.
  - Then go to IDLE with rsp_valid = 0 on the next cycle.
  - No request is accepted in the RESP cycle itself, so the maximum throughput is one access per LATENCY+2 cycles when rsp_ready is held high.
- Unsupported funct3 (3, 6, 7):
  - Store: no RAM change.
  - Load: rsp_rdata = 0.
  - rsp_err = 1 only when DMEM_MISALIGN_EN is defined.
  - Still produces a normal response.
- Inputs that change after accept are ignored, because the fields are latched.
- Reset:
  - State → IDLE; req_ready = 1 in the following cycle.
  - rsp_valid = 0, rsp_rdata = 0, rsp_err = 0.
  - RAM contents are not cleared.
- Reset mid-operation:
  - During WAIT: the pending access is dropped, and a store that has not reached its commit edge does not modify the RAM.
  - During RESP: the response is discarded.
  - Reset takes priority over the commit in the same cycle.

Optional Feature:
- Macro: DMEM_MISALIGN_EN.
- Defined:
  - A misaligned access is a halfword with addr[0] = 1, or a word with addr[1:0] ≠ 0.
  - It, or an unsupported funct3, completes with rsp_err = 1 and rsp_rdata = 0.
  - A store that faults is suppressed.
  - Timing is identical to a normal access.
- Undefined:
  - rsp_err is tied to 0.
  - Misaligned addresses are forced aligned: the low bit is cleared for halfwords, the low two bits for words.
  - The access then proceeds normally.

Test Plan:
- LATENCY=2: SW 0xDEADBEEF @0x10, then LW @0x10 → rsp_rdata 0xDEADBEEF, rsp_valid rising exactly 3 cycles after each accept; req_ready low from accept until rsp handshake.
- SW 0x11223344 @0x4, then SB 0xAA @0x5, then LW @0x4 → 0x1122AA44. Then LH @0x6 → 0x00001122 and LHU @0x4 → 0x0000AA44.
- Byte 0x80 stored @0x8, then LB @0x8 → 0xFFFFFF80; LBU @0x8 → 0x00000080.
- rsp_ready held low for 3 cycles in RESP → rsp_valid and rsp_rdata stable throughout; a req_valid held high during RESP is not accepted until after the handshake and return to IDLE.
- SW 0x12345678 @0x20, with reset asserted in the first WAIT cycle, then LW @0x20 → old contents returned; outputs are 0 and req_ready = 1 the cycle after reset is released.
- LW @0x2 (RAM word 0 = 0xCAFEF00D):
  - With DMEM_MISALIGN_EN → rsp_err = 1, rsp_rdata = 0.
  - Without it → rsp_rdata 0xCAFEF00D, rsp_err = 0.
  - LATENCY=0 build → rsp_valid 1 cycle after accept.
